// File: rtl/zynet_pkg.sv
// Shared zyNet definitions: loader FSM states, layer indices and the default
// parameter-RAM geometry used by both the network and the weight loader.
package zynet_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;

  localparam int CONV0 = 0;
  localparam int FC0   = 1;
  localparam int BN0   = 2;
  localparam int FC1   = 3;
  localparam int NUM_LAYERS = 4;

  localparam int DEF_MEM_WORD_SIZE     = 21;
  localparam int DEF_LAYER_SELECT_BITS = 2;
  localparam int DEF_RAM_SELECT_BITS   = 8;
  localparam int DEF_RAM_ADDRESS_BITS  = 9;
  localparam int DEF_L0_RAMS  = 256;
  localparam int DEF_L0_DEPTH = 33;
  localparam int DEF_L1_RAMS  = 256;
  localparam int DEF_L1_DEPTH = 257;
  localparam int DEF_L2_RAMS  = 4;
  localparam int DEF_L2_DEPTH = 256;
  localparam int DEF_L3_RAMS  = 10;
  localparam int DEF_L3_DEPTH = 257;
endpackage

// File: rtl/weight_addr_counter.sv
// Mixed-radix {layer, ram, addr} counter; the ram/addr wrap limits are chosen
// by the current layer so each layer can have its own geometry.
module weight_addr_counter
  import zynet_pkg::*;
#(
  parameter int LSB = 2,
  parameter int RSB = 8,
  parameter int RAB = 9
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clr_i,
  input  logic                                 inc_i,
  input  logic [NUM_LAYERS-1:0][RSB-1:0]       ram_lim_i,
  input  logic [NUM_LAYERS-1:0][RAB-1:0]       depth_lim_i,
  output logic [LSB+RSB+RAB-1:0]               addr_o,
  output logic                                 last_o
);
  logic [LSB-1:0] layer_q, layer_d;
  logic [RSB-1:0] ram_q, ram_d;
  logic [RAB-1:0] addr_q, addr_d;

  always_comb begin
    layer_d = layer_q;
    ram_d   = ram_q;
    addr_d  = addr_q;
    if (clr_i) begin
      layer_d = '0;
      ram_d   = '0;
      addr_d  = '0;
    end else if (inc_i) begin
      if (addr_q == depth_lim_i[layer_q]) begin
        addr_d = '0;
        if (ram_q == ram_lim_i[layer_q]) begin
          ram_d   = '0;
          layer_d = layer_q + 1'b1;
        end else begin
          ram_d = ram_q + 1'b1;
        end
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      layer_q <= '0;
      ram_q   <= '0;
      addr_q  <= '0;
    end else begin
      layer_q <= layer_d;
      ram_q   <= ram_d;
      addr_q  <= addr_d;
    end
  end

  assign addr_o = {layer_q, ram_q, addr_q};
  assign last_o = (layer_q == LSB'(FC1)) && (ram_q == ram_lim_i[FC1]) &&
                  (addr_q == depth_lim_i[FC1]);
endmodule

// File: rtl/zynet_weight_loader.sv
// Streams raw parameter words into every zyNet parameter RAM, generating the
// {layer, ram, addr} write address and reporting when a full set is loaded.
module zynet_weight_loader
  import zynet_pkg::*;
#(
  parameter int MEM_WORD_SIZE     = DEF_MEM_WORD_SIZE,
  parameter int LAYER_SELECT_BITS = DEF_LAYER_SELECT_BITS,
  parameter int RAM_SELECT_BITS   = DEF_RAM_SELECT_BITS,
  parameter int RAM_ADDRESS_BITS  = DEF_RAM_ADDRESS_BITS,
  parameter int L0_RAMS  = DEF_L0_RAMS,
  parameter int L0_DEPTH = DEF_L0_DEPTH,
  parameter int L1_RAMS  = DEF_L1_RAMS,
  parameter int L1_DEPTH = DEF_L1_DEPTH,
  parameter int L2_RAMS  = DEF_L2_RAMS,
  parameter int L2_DEPTH = DEF_L2_DEPTH,
  parameter int L3_RAMS  = DEF_L3_RAMS,
  parameter int L3_DEPTH = DEF_L3_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic [MEM_WORD_SIZE-1:0] data_i,
  output logic                     ready_o,
  output logic                     w_en_o,
  output logic [MEM_WORD_SIZE-1:0] w_data_o,
  output logic [LAYER_SELECT_BITS+RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] w_addr_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     loaded_o
);
  localparam int AW = LAYER_SELECT_BITS + RAM_SELECT_BITS + RAM_ADDRESS_BITS;

  // Limits are stored as "last index" so the counter compares without subtracting.
  localparam logic [NUM_LAYERS-1:0][RAM_SELECT_BITS-1:0] RAM_LIM = {
    RAM_SELECT_BITS'(L3_RAMS - 1), RAM_SELECT_BITS'(L2_RAMS - 1),
    RAM_SELECT_BITS'(L1_RAMS - 1), RAM_SELECT_BITS'(L0_RAMS - 1)};
  localparam logic [NUM_LAYERS-1:0][RAM_ADDRESS_BITS-1:0] DEPTH_LIM = {
    RAM_ADDRESS_BITS'(L3_DEPTH - 1), RAM_ADDRESS_BITS'(L2_DEPTH - 1),
    RAM_ADDRESS_BITS'(L1_DEPTH - 1), RAM_ADDRESS_BITS'(L0_DEPTH - 1)};

  loader_state_t          state_q;
  logic                   ready_q, busy_q, done_q, loaded_q, w_en_q;
  logic [MEM_WORD_SIZE-1:0] w_data_q;
  logic [AW-1:0]          w_addr_q;
  logic [AW-1:0]          cnt_addr;
  logic                   cnt_last;
  logic                   hs, clr;

  assign hs  = valid_i & ready_q;
  assign clr = start_i & (state_q != LOAD);

  weight_addr_counter #(
    .LSB(LAYER_SELECT_BITS),
    .RSB(RAM_SELECT_BITS),
    .RAB(RAM_ADDRESS_BITS)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (reset_i),
    .clr_i      (clr),
    .inc_i      (hs),
    .ram_lim_i  (RAM_LIM),
    .depth_lim_i(DEPTH_LIM),
    .addr_o     (cnt_addr),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      w_en_q   <= 1'b0;
      w_data_q <= '0;
      w_addr_q <= '0;
    end else begin
      w_en_q <= hs;
      done_q <= 1'b0;
      if (hs) begin
        w_data_q <= data_i;
        w_addr_q <= cnt_addr;
      end
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_q  <= LOAD;
          ready_q  <= 1'b1;
          busy_q   <= 1'b1;
          loaded_q <= 1'b0;
        end
        LOAD: if (hs && cnt_last) begin
          state_q  <= DONE;
          ready_q  <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          loaded_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign loaded_o = loaded_q;
  assign w_en_o   = w_en_q;
  assign w_data_o = w_data_q;
  assign w_addr_o = w_addr_q;
endmodule
